// File: rtl/web_pkg.sv
// Shared types and store limits for the web resource ledger.
package web_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_RESP   = 2'd2,
        ST_RELOAD = 2'd3
    } state_e;

    localparam logic [3:0] FLUID_FULL   = 4'd15;
    localparam logic [7:0] ENERGY_FULL  = 8'd255;
    localparam logic [5:0] TRACERS_FULL = 6'd63;

    // Clamp a 9-bit intermediate energy value back into the 8-bit store.
    function automatic logic [7:0] sat_energy(input logic [8:0] v);
        return v[8] ? ENERGY_FULL : v[7:0];
    endfunction

endpackage

// File: rtl/web_recharge_timer.sv
// Free-running period counter; tick is high for one cycle every PERIOD cycles.
module web_recharge_timer #(
    parameter int PERIOD = 8
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    logic [15:0] cnt_q, cnt_d;

    // Tick on the last count of each period.
    always_comb begin
        tick  = (cnt_q == 16'(PERIOD - 1));
        cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    end

    // Period counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= 16'd0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/web_resource_ledger.sv
// Resource ledger: grants/denies fluid, energy and tracer demands against
// on-chip stores, with fluid cartridge reload.
// Optional feature: define WEB_RECHARGE_EN for periodic +1 energy recharge.
module web_resource_ledger
    import web_pkg::*;
#(
    parameter int RELOAD_CYCLES   = 4,
    parameter int RECHARGE_PERIOD = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] web_needed,
    input  logic [7:0] energy_needed,
    input  logic [5:0] tracers_needed,
    input  logic       reload,
    output logic       resp_valid,
    output logic       resp_granted,
    output logic [3:0] fluid,
    output logic [7:0] energy,
    output logic [5:0] tracers,
    output logic       busy
);

    state_e     state_q, state_d;
    logic [3:0] fluid_q, fluid_d;
    logic [7:0] energy_q, energy_d;
    logic [5:0] tracers_q, tracers_d;
    logic [3:0] web_need_q, web_need_d;
    logic [7:0] energy_need_q, energy_need_d;
    logic [5:0] tracers_need_q, tracers_need_d;
    logic [7:0] reload_cnt_q, reload_cnt_d;
    logic       resp_valid_q, resp_valid_d;
    logic       resp_granted_q, resp_granted_d;
    logic       req_ready_q, req_ready_d;
    logic       busy_q, busy_d;
    logic       commit;
    logic       recharge_tick;
    logic [8:0] energy_next;

`ifdef WEB_RECHARGE_EN
    web_recharge_timer #(.PERIOD(RECHARGE_PERIOD)) u_recharge (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (recharge_tick)
    );
`else
    // Recharge compiled out: energy can only go down until reset.
    logic unused_recharge_period;
    assign recharge_tick          = 1'b0;
    assign unused_recharge_period = (RECHARGE_PERIOD > 0);
`endif

    // Next-state, demand capture, store update and registered output decode.
    always_comb begin
        state_d        = state_q;
        fluid_d        = fluid_q;
        tracers_d      = tracers_q;
        web_need_d     = web_need_q;
        energy_need_d  = energy_need_q;
        tracers_need_d = tracers_need_q;
        reload_cnt_d   = reload_cnt_q;
        resp_valid_d   = 1'b0;
        resp_granted_d = 1'b0;
        commit         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Reload wins over a simultaneous request.
                if (reload) begin
                    state_d      = ST_RELOAD;
                    reload_cnt_d = 8'(RELOAD_CYCLES - 1);
                end else if (req_valid && req_ready_q) begin
                    state_d        = ST_CHECK;
                    web_need_d     = web_needed;
                    energy_need_d  = energy_needed;
                    tracers_need_d = tracers_needed;
                end
            end
            ST_CHECK: begin
                state_d        = ST_RESP;
                resp_valid_d   = 1'b1;
                resp_granted_d = (fluid_q   >= web_need_q)    &&
                                 (energy_q  >= energy_need_q) &&
                                 (tracers_q >= tracers_need_q);
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                // Grant guarantees every store covers its demand: no underflow.
                if (resp_granted_q) begin
                    commit    = 1'b1;
                    fluid_d   = fluid_q - web_need_q;
                    tracers_d = tracers_q - tracers_need_q;
                end
            end
            ST_RELOAD: begin
                if (reload_cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                    fluid_d = FLUID_FULL;
                end else begin
                    reload_cnt_d = reload_cnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Commit and recharge combine in 9 bits, then saturate at full.
        energy_next = {1'b0, energy_q}
                    - (commit ? {1'b0, energy_need_q} : 9'd0)
                    + {8'd0, recharge_tick};
        energy_d    = sat_energy(energy_next);

        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and store registers; reset aborts any operation and refills stores.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            fluid_q        <= FLUID_FULL;
            energy_q       <= ENERGY_FULL;
            tracers_q      <= TRACERS_FULL;
            web_need_q     <= 4'd0;
            energy_need_q  <= 8'd0;
            tracers_need_q <= 6'd0;
            reload_cnt_q   <= 8'd0;
            resp_valid_q   <= 1'b0;
            resp_granted_q <= 1'b0;
            req_ready_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            fluid_q        <= fluid_d;
            energy_q       <= energy_d;
            tracers_q      <= tracers_d;
            web_need_q     <= web_need_d;
            energy_need_q  <= energy_need_d;
            tracers_need_q <= tracers_need_d;
            reload_cnt_q   <= reload_cnt_d;
            resp_valid_q   <= resp_valid_d;
            resp_granted_q <= resp_granted_d;
            req_ready_q    <= req_ready_d;
            busy_q         <= busy_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_granted = resp_granted_q;
    assign fluid        = fluid_q;
    assign energy       = energy_q;
    assign tracers      = tracers_q;
    assign busy         = busy_q;

endmodule

// File: doc/web_resource_ledger.md
WEB_RESOURCE_LEDGER -- requirements
Module: web_resource_ledger

Interface
REQ-001 SHALL have parameter RELOAD_CYCLES, default 4, cycles spent in cartridge reload before fluid refills.
REQ-002 SHALL have parameter RECHARGE_PERIOD, default 8, cycles per +1 energy recharge tick.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  fire request with demand present.
REQ-006 SHALL have port req_ready  output  1  ledger can accept a request.
REQ-007 SHALL have port web_needed  input  4  fluid units demanded.
REQ-008 SHALL have port energy_needed  input  8  energy units demanded.
REQ-009 SHALL have port tracers_needed  input  6  tracers demanded.
REQ-010 SHALL have port reload  input  1  request fluid cartridge reload.
REQ-011 SHALL have port resp_valid  output  1  one-cycle verdict strobe.
REQ-012 SHALL have port resp_granted  output  1  verdict, qualified by resp_valid.
REQ-013 SHALL have ports fluid/energy/tracers  output  4/8/6  current stores.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, CHECK, RESP, RELOAD.
REQ-016 req_ready SHALL be 1 only in IDLE; request accepted when req_valid && req_ready; demand captured into registers on that edge; IDLE->CHECK.
REQ-017 CHECK SHALL compute grant = (fluid>=web) && (energy>=energy_need) && (tracers>=tracers_need) from captured demand; CHECK->RESP.
REQ-018 RESP SHALL drive resp_valid=1 for exactly one cycle; on the edge leaving RESP, stores decrement by captured demand only if granted; RESP->IDLE.
REQ-019 resp_valid SHALL rise two cycles after the accepting edge; back-to-back requests accepted every third cycle.
REQ-020 Zero demand SHALL be granted with no store change; exact-equal demand SHALL be granted leaving that store at 0.
REQ-021 Denial SHALL leave all stores unchanged.
REQ-022 In IDLE, reload SHALL take priority over simultaneous req_valid; IDLE->RELOAD, req_valid ignored that cycle.
REQ-023 RELOAD SHALL last exactly RELOAD_CYCLES cycles via down-counter; on final edge fluid=15; ->IDLE. Energy and tracers untouched by reload.
REQ-024 reload asserted outside IDLE SHALL be ignored (not queued).
REQ-025 Store arithmetic SHALL be unsigned; no store ever wraps below 0 or above full.

Reset
REQ-026 On reset_n low: state=IDLE, fluid=15, energy=255, tracers=63, resp_valid=0, resp_granted=0, busy=0, req_ready=0 while asserted, counters=0.
REQ-027 Reset mid-RELOAD or mid-CHECK/RESP SHALL abort the operation; no partial decrement; stores return to full values.

Configuration
REQ-028 Macro WEB_RECHARGE_EN defined: energy +1 every RECHARGE_PERIOD cycles in all states, saturating at 255; on coincidence with a granted commit, energy = energy - need + 1 computed 9-bit, saturated.
REQ-029 WEB_RECHARGE_EN undefined: no recharge logic; energy only decreases, restored only by reset.

Structure
REQ-030 Shared package web_pkg SHALL hold state enum, FLUID_FULL=15, ENERGY_FULL=255, TRACERS_FULL=63.
REQ-031 Sub-module web_recharge_timer (period counter emitting one-cycle tick) SHALL exist, instantiated only under WEB_RECHARGE_EN.

Verification
REQ-032 Reset, then req web=1/energy=16/tracers=8 -> resp_valid at +2 cycles, granted=1; stores 14/239/55.
REQ-033 Stores energy=3, req energy=4 web=1 -> granted=0; stores unchanged.
REQ-034 reload and req_valid same IDLE cycle -> RELOAD entered, busy=1 for 4 cycles, fluid=15, no resp_valid.
REQ-035 Req web=15 energy=0 tracers=0 from full -> granted, fluid=0; next req web=1 -> denied.
REQ-036 reset_n pulsed low during RELOAD cycle 2 -> IDLE, fluid=15, no resp_valid afterwards.
REQ-037 WEB_RECHARGE_EN, energy=255, grant energy=1 on tick cycle -> energy stays 255; idle 8 cycles after energy=250 -> 251.
